branch_cond_unit: RTL and testbench
===================================

// Module: branch_cond_unit
// PURPOSE
//  Execute-stage consumer of the ALU condition codes {V,C,N,Z}: evaluates a branch condition,
//  computes the target (PC + displacement), and on a taken branch redirects fetch and holds a
//  pipeline flush for FLUSH_CYCLES cycles. It also bypasses flags being written in the same cycle.
// PARAMETERS
//  WIDTH         32  datapath / PC width
//  FLUSH_CYCLES  2   cycles o_flush stays high after a taken branch (0 = no flush phase)
//  STAT_W        16  width of statistics counters (used only with BCU_STATS_EN)
// PORTS
//  clk            in   1      clock
//  reset          in   1      synchronous, active-high
//  i_valid        in   1      branch instruction presented
//  o_ready        out  1      unit can accept a branch this cycle
//  i_cond         in   4      condition field (encoding below)
//  i_pc           in   WIDTH  PC of the branch
//  i_disp         in   WIDTH  sign-extended displacement
//  i_ccodes       in   4      architectural flags [0]=Z [1]=N [2]=C [3]=V
//  i_cc_fwd_vld   in   1      an older instruction writes flags this cycle
//  i_cc_fwd       in   4      flags being written (same bit order)
//  o_redirect     out  1      1-cycle pulse: fetch must load o_target
//  o_target       out  WIDTH  branch target, valid while o_redirect is high
//  o_resolved     out  1      1-cycle pulse: branch resolved (taken or not)
//  o_taken        out  1      outcome of the last resolved branch, held until the next one
//  o_flush        out  1      squash younger instructions
//  o_br_cnt       out  STAT_W branches resolved (BCU_STATS_EN only)
//  o_tk_cnt       out  STAT_W branches taken (BCU_STATS_EN only)
// BEHAVIOUR
//  - Effective flags F = i_cc_fwd_vld ? i_cc_fwd : i_ccodes, sampled at acceptance.
//  - Conditions: 0 BRA=1; 1 BNV=0; 2 BCC=~C; 3 BCS=C; 4 BVC=~V; 5 BVS=V; 6 BEQ=Z; 7 BNE=~Z;
//    8 BGE=~(N^V); 9 BLT=N^V; 10 BGT=~Z&~(N^V); 11 BLE=Z|(N^V); 12 BPL=~N; 13 BMI=N;
//    14,15 reserved: always evaluate not-taken.
//  - Target = i_pc + i_disp, modulo 2^WIDTH (wrap-around, no carry kept).
//  - Acceptance: i_valid & o_ready at edge T. Registered outputs update at T+1 (1-cycle latency).
//  - FSM IDLE / FLUSH:
//    IDLE: o_ready=1. On accept, o_resolved=1 at T+1 and o_taken is loaded.
//      If taken: o_redirect=1 and o_target=target at T+1. If FLUSH_CYCLES>0, enter FLUSH with
//      counter=FLUSH_CYCLES; if FLUSH_CYCLES==0, stay IDLE.
//      If not taken: stay IDLE, with o_redirect=0 and o_flush=0.
//    FLUSH: o_flush=1 and o_ready=0. The counter decrements each cycle; the FSM leaves to IDLE
//      after exactly FLUSH_CYCLES cycles of o_flush. o_flush first rises in the same cycle as
//      o_redirect. i_valid is ignored while in FLUSH.
//  - Back-to-back not-taken branches are accepted every cycle.
//  - reset (also mid-FLUSH) at the next edge: state=IDLE, counter=0, o_redirect=0, o_resolved=0,
//    o_taken=0, o_flush=0, o_target=0, counters=0. o_ready=1 in the cycle after reset.
// CONFIGURATION
//  BCU_STATS_EN defined:
//    - o_br_cnt increments on each o_resolved; o_tk_cnt increments on each resolved taken branch.
//    - Both counters saturate at all-ones and clear on reset.
//  BCU_STATS_EN undefined: counters absent; o_br_cnt and o_tk_cnt are tied to 0.
// STRUCTURE
//  - Shared package: condition-code index constants (ZERO=0, NEGATIVE=1, CARRY=2, OVERFLOW=3),
//    4-bit condition encodings BR_*, and FSM state typedef {BCU_IDLE, BCU_FLUSH}.
//  - One sub-module, bcu_cond_eval: combinational (flags, cond) -> taken. It is reused by the
//    decode-stage predictor.
// TESTING
//  1. reset high 2 cycles -> all outputs 0, o_ready=1; then BRA pc=0x100 disp=0x20
//     -> T+1: o_redirect=1, o_target=0x120, o_taken=1, then o_flush high 2 cycles.
//  2. BEQ with i_ccodes=4'b0000, i_cc_fwd_vld=1, i_cc_fwd=4'b0001 -> taken (bypass wins);
//     same stimulus with i_cc_fwd_vld=0 -> not taken, o_resolved=1, o_flush=0.
//  3. Sweep all 16 conds x 16 flag values -> o_taken matches the table; 14/15 never taken.
//  4. pc=0xFFFFFFF0, disp=0x20, BRA -> o_target=0x00000010 (wraps).
//  5. i_valid held during FLUSH -> no extra o_resolved; reset asserted in the 1st flush cycle
//     -> o_flush=0 next cycle, o_ready=1.
//  6. BCU_STATS_EN: 5 branches, 3 taken -> o_br_cnt=5, o_tk_cnt=3; with STAT_W=2 and 5 branches
//     -> o_br_cnt saturates at 3.

Source files
------------

// File: rtl/branch_cond_unit_pkg.sv
// branch_cond_unit_pkg: flag indices, branch condition encodings and FSM state type
package branch_cond_unit_pkg;
  localparam int ZERO     = 0;
  localparam int NEGATIVE = 1;
  localparam int CARRY    = 2;
  localparam int OVERFLOW = 3;
  localparam logic [3:0] BR_BRA = 4'd0;
  localparam logic [3:0] BR_BNV = 4'd1;
  localparam logic [3:0] BR_BCC = 4'd2;
  localparam logic [3:0] BR_BCS = 4'd3;
  localparam logic [3:0] BR_BVC = 4'd4;
  localparam logic [3:0] BR_BVS = 4'd5;
  localparam logic [3:0] BR_BEQ = 4'd6;
  localparam logic [3:0] BR_BNE = 4'd7;
  localparam logic [3:0] BR_BGE = 4'd8;
  localparam logic [3:0] BR_BLT = 4'd9;
  localparam logic [3:0] BR_BGT = 4'd10;
  localparam logic [3:0] BR_BLE = 4'd11;
  localparam logic [3:0] BR_BPL = 4'd12;
  localparam logic [3:0] BR_BMI = 4'd13;
  typedef enum logic {BCU_IDLE, BCU_FLUSH} bcu_state_t;
endpackage

// File: rtl/branch_cond_unit_cond_eval.sv
// bcu_cond_eval: combinational branch condition evaluation from {V,C,N,Z}
module bcu_cond_eval
  import branch_cond_unit_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       taken
);
  logic lt;
  assign lt = flags[NEGATIVE] ^ flags[OVERFLOW];
  // decode the condition; reserved encodings fall through to not-taken
  always_comb begin
    taken = 1'b0;
    case (cond)
      BR_BRA: taken = 1'b1;
      BR_BNV: taken = 1'b0;
      BR_BCC: taken = ~flags[CARRY];
      BR_BCS: taken = flags[CARRY];
      BR_BVC: taken = ~flags[OVERFLOW];
      BR_BVS: taken = flags[OVERFLOW];
      BR_BEQ: taken = flags[ZERO];
      BR_BNE: taken = ~flags[ZERO];
      BR_BGE: taken = ~lt;
      BR_BLT: taken = lt;
      BR_BGT: taken = ~flags[ZERO] & ~lt;
      BR_BLE: taken = flags[ZERO] | lt;
      BR_BPL: taken = ~flags[NEGATIVE];
      BR_BMI: taken = flags[NEGATIVE];
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_cond_unit.sv
// branch_cond_unit: branch resolve, redirect and flush sequencing; BCU_STATS_EN adds statistics counters
module branch_cond_unit
  import branch_cond_unit_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int STAT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_cond,
  input  logic [WIDTH-1:0]  i_pc,
  input  logic [WIDTH-1:0]  i_disp,
  input  logic [3:0]        i_ccodes,
  input  logic              i_cc_fwd_vld,
  input  logic [3:0]        i_cc_fwd,
  output logic              o_redirect,
  output logic [WIDTH-1:0]  o_target,
  output logic              o_resolved,
  output logic              o_taken,
  output logic              o_flush,
  output logic [STAT_W-1:0] o_br_cnt,
  output logic [STAT_W-1:0] o_tk_cnt
);
  localparam int CW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES + 1) : 1;
  bcu_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] flags;
  logic take, accept;
  assign flags  = i_cc_fwd_vld ? i_cc_fwd : i_ccodes;
  assign accept = i_valid & o_ready;
  bcu_cond_eval u_eval (.flags(flags), .cond(i_cond), .taken(take));
  // state and flush counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BCU_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
  // a taken branch opens the flush window; it closes when the counter reaches its last cycle
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (state == BCU_IDLE) begin
      if (accept && take && FLUSH_CYCLES > 0) begin
        state_n = BCU_FLUSH;
        cnt_n   = CW'(FLUSH_CYCLES);
      end
    end else begin
      cnt_n   = cnt - CW'(1);
      state_n = (cnt == CW'(1)) ? BCU_IDLE : BCU_FLUSH;
    end
  end
  // handshake and squash follow the state directly
  always_comb begin
    o_ready = (state == BCU_IDLE);
    o_flush = (state == BCU_FLUSH);
  end
  // resolve outputs, one cycle after acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      o_redirect <= 1'b0;
      o_resolved <= 1'b0;
      o_taken    <= 1'b0;
      o_target   <= '0;
    end else begin
      o_redirect <= accept & take;
      o_resolved <= accept;
      if (accept) o_taken <= take;
      if (accept && take) o_target <= i_pc + i_disp;
    end
  end
`ifdef BCU_STATS_EN
  logic [STAT_W-1:0] br_cnt, tk_cnt;
  // saturating counters of resolved and taken branches
  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt <= '0;
      tk_cnt <= '0;
    end else if (accept) begin
      br_cnt <= br_cnt + STAT_W'(br_cnt != '1);
      tk_cnt <= tk_cnt + STAT_W'(take && tk_cnt != '1);
    end
  end
  assign o_br_cnt = br_cnt;
  assign o_tk_cnt = tk_cnt;
`else
  assign o_br_cnt = '0;
  assign o_tk_cnt = '0;
`endif
endmodule

// File: tb/tb_branch_cond_unit.sv
// tb_branch_cond_unit: randomized and directed checks of branch_cond_unit against a behavioural model
module tb_branch_cond_unit;
  localparam int FC = 2;
  logic clk = 0, reset = 1, i_valid = 0, i_cc_fwd_vld = 0;
  logic [3:0] i_cond = 0, i_ccodes = 0, i_cc_fwd = 0;
  logic [31:0] i_pc = 0, i_disp = 0;
  logic o_ready, o_redirect, o_resolved, o_taken, o_flush;
  logic [31:0] o_target;
  logic [15:0] o_br_cnt, o_tk_cnt;
  logic r2_ready, r2_redirect, r2_resolved, r2_taken, r2_flush;
  logic [31:0] r2_target;
  logic [1:0] r2_br_cnt, r2_tk_cnt;
  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  branch_cond_unit #(.WIDTH(32), .FLUSH_CYCLES(FC), .STAT_W(16)) u_dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready), .i_cond(i_cond),
    .i_pc(i_pc), .i_disp(i_disp), .i_ccodes(i_ccodes), .i_cc_fwd_vld(i_cc_fwd_vld),
    .i_cc_fwd(i_cc_fwd), .o_redirect(o_redirect), .o_target(o_target),
    .o_resolved(o_resolved), .o_taken(o_taken), .o_flush(o_flush),
    .o_br_cnt(o_br_cnt), .o_tk_cnt(o_tk_cnt));

  branch_cond_unit #(.WIDTH(32), .FLUSH_CYCLES(0), .STAT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(r2_ready), .i_cond(i_cond),
    .i_pc(i_pc), .i_disp(i_disp), .i_ccodes(i_ccodes), .i_cc_fwd_vld(i_cc_fwd_vld),
    .i_cc_fwd(i_cc_fwd), .o_redirect(r2_redirect), .o_target(r2_target),
    .o_resolved(r2_resolved), .o_taken(r2_taken), .o_flush(r2_flush),
    .o_br_cnt(r2_br_cnt), .o_tk_cnt(r2_tk_cnt));

  function automatic bit exp_take(int c, bit [3:0] f);
    bit z = f[0], n = f[1], cy = f[2], v = f[3];
    case (c)
      0: return 1;
      1: return 0;
      2: return !cy;
      3: return cy;
      4: return !v;
      5: return v;
      6: return z;
      7: return !z;
      8: return n == v;
      9: return n != v;
      10: return !z && n == v;
      11: return z || n != v;
      12: return !n;
      13: return n;
      default: return 0;
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // behavioural model: flush_left counts remaining squash cycles
  int m_left = 0, m_br = 0, m_tkc = 0, m2_br = 0, m2_tkc = 0;
  bit m_red = 0, m_res = 0, m_tk = 0, m2_red = 0, m2_res = 0, m2_tk = 0, acc = 0, t = 0;
  logic [31:0] m_tgt = 0, m2_tgt = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0; m_red = 0; m_res = 0; m_tk = 0; m_tgt = 0; m_br = 0; m_tkc = 0;
      m2_red = 0; m2_res = 0; m2_tk = 0; m2_tgt = 0; m2_br = 0; m2_tkc = 0;
    end else begin
      t = exp_take(int'(i_cond), i_cc_fwd_vld ? i_cc_fwd : i_ccodes);
      acc = i_valid && m_left == 0;
      if (m_left > 0) m_left--;
      m_res = acc;
      m_red = acc && t;
      if (acc) begin
        m_tk = t;
        if (m_br < 65535) m_br++;
        if (t && m_tkc < 65535) m_tkc++;
      end
      if (acc && t) begin
        m_tgt = i_pc + i_disp;
        m_left = FC;
      end
      m2_res = i_valid;
      m2_red = i_valid && t;
      if (i_valid) begin
        m2_tk = t;
        if (m2_br < 3) m2_br++;
        if (t && m2_tkc < 3) m2_tkc++;
        if (t) m2_tgt = i_pc + i_disp;
      end
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    chk("ready", o_ready, m_left == 0);
    chk("flush", o_flush, m_left > 0);
    chk("redirect", o_redirect, m_red);
    chk("resolved", o_resolved, m_res);
    chk("taken", o_taken, m_tk);
    if (m_red) chk("target", o_target, m_tgt);
    chk("ready2", r2_ready, 1'b1);
    chk("flush2", r2_flush, 1'b0);
    chk("redirect2", r2_redirect, m2_red);
    chk("resolved2", r2_resolved, m2_res);
    chk("taken2", r2_taken, m2_tk);
    if (m2_red) chk("target2", r2_target, m2_tgt);
`ifdef BCU_STATS_EN
    chk("br_cnt", o_br_cnt, m_br);
    chk("tk_cnt", o_tk_cnt, m_tkc);
    chk("br_cnt2", r2_br_cnt, m2_br);
    chk("tk_cnt2", r2_tk_cnt, m2_tkc);
`else
    chk("br_cnt", o_br_cnt, 0);
    chk("tk_cnt", o_tk_cnt, 0);
    chk("br_cnt2", r2_br_cnt, 0);
    chk("tk_cnt2", r2_tk_cnt, 0);
`endif
  end

  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic br(bit v, bit [3:0] c, logic [31:0] pc, logic [31:0] d, bit [3:0] cc, bit fv, bit [3:0] fw);
    i_valid = v; i_cond = c; i_pc = pc; i_disp = d; i_ccodes = cc; i_cc_fwd_vld = fv; i_cc_fwd = fw;
  endtask

  initial begin
    reset = 1;
    cycle(); cycle();
    chk("lit_rst_ready", o_ready, 1'b1);
    chk("lit_rst_outs", {o_redirect, o_resolved, o_taken, o_flush}, 4'b0000);
    chk("lit_rst_target", o_target, 32'h0);
    reset = 0;
    br(1, 4'd0, 32'h100, 32'h20, 4'h0, 0, 4'h0);
    cycle();
    chk("lit_bra_redirect", {o_redirect, o_resolved, o_taken, o_flush}, 4'b1111);
    chk("lit_bra_target", o_target, 32'h120);
    i_valid = 0;
    cycle();
    chk("lit_bra_flush2", {o_flush, o_ready, o_redirect}, 3'b100);
    cycle();
    chk("lit_bra_done", {o_flush, o_ready}, 2'b01);
    br(1, 4'd6, 32'h40, 32'h8, 4'b0000, 1, 4'b0001);
    cycle();
    chk("lit_beq_bypass", {o_resolved, o_taken, o_redirect}, 3'b111);
    i_valid = 0;
    cycle(); cycle();
    br(1, 4'd6, 32'h40, 32'h8, 4'b0000, 0, 4'b0001);
    cycle();
    chk("lit_beq_nobypass", {o_resolved, o_taken, o_redirect, o_flush}, 4'b1000);
    br(1, 4'd1, 32'h0, 32'h0, 4'h0, 0, 4'h0);
    cycle();
    chk("lit_b2b_nt", {o_resolved, o_ready}, 2'b11);
    br(1, 4'd0, 32'hFFFF_FFF0, 32'h20, 4'h0, 0, 4'h0);
    cycle();
    chk("lit_wrap", o_target, 32'h0000_0010);
    cycle();
    chk("lit_hold_valid", {o_resolved, o_flush}, 2'b01);
    cycle();
    chk("lit_hold_valid2", {o_resolved, o_flush, o_ready}, 3'b001);
    cycle();
    chk("lit_reaccept", o_resolved, 1'b1);
    reset = 1;
    cycle();
    chk("lit_rst_midflush", {o_flush, o_ready, o_resolved}, 3'b010);
    reset = 0; i_valid = 0;
    cycle();
    for (int c = 0; c < 16; c++)
      for (int f = 0; f < 16; f++) begin
        br(1, 4'(c), 32'(c * 16), 32'(f), 4'(f), 0, 4'h0);
        cycle();
        if (c == 10 && f == 0) chk("lit_bgt_f0", o_taken, 1'b1);
        if (c == 10 && f == 1) chk("lit_bgt_z", o_taken, 1'b0);
        if (c == 8 && f == 10) chk("lit_bge_nv", o_taken, 1'b1);
        if (c == 9 && f == 2) chk("lit_blt_n", o_taken, 1'b1);
        if (c >= 14 && f == 15) chk("lit_reserved", o_taken, 1'b0);
        i_valid = 0;
        cycle(); cycle();
      end
    reset = 1;
    cycle();
    reset = 0;
    br(1, 4'd0, 0, 0, 4'h0, 0, 4'h0); cycle(); i_valid = 0; cycle(); cycle();
    br(1, 4'd1, 0, 0, 4'h0, 0, 4'h0); cycle(); i_valid = 0; cycle(); cycle();
    br(1, 4'd0, 0, 0, 4'h0, 0, 4'h0); cycle(); i_valid = 0; cycle(); cycle();
    br(1, 4'd6, 0, 0, 4'h1, 0, 4'h0); cycle(); i_valid = 0; cycle(); cycle();
    br(1, 4'd7, 0, 0, 4'h1, 0, 4'h0); cycle(); i_valid = 0; cycle(); cycle();
`ifdef BCU_STATS_EN
    chk("lit_br5", o_br_cnt, 16'd5);
    chk("lit_tk3", o_tk_cnt, 16'd3);
    chk("lit_br_sat", r2_br_cnt, 2'd3);
`else
    chk("lit_br_off", o_br_cnt, 16'd0);
    chk("lit_tk_off", o_tk_cnt, 16'd0);
    chk("lit_br2_off", r2_br_cnt, 2'd0);
`endif
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      br($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom, $urandom,
         4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
      cycle();
    end
    reset = 0; i_valid = 0;
    cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
